step_pulse_gen: RTL and testbench

STEP_PULSE_GEN -- requirements
Module: step_pulse_gen

---
 rtl/step_pulse_gen.sv | 156 +++++++++++++++
 tb/tb_step_pulse_gen.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/step_pulse_gen.sv
// Debounced up/down button to single-cycle add/sub strobe generator.
// Define STEP_PULSE_AUTO_REPEAT_EN to enable auto-repeat while a button is held.
module step_pulse_gen #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int REPEAT_DELAY    = 16,
  parameter int REPEAT_PERIOD   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_up,
  input  logic       btn_dn,
  input  logic       hold,
  output logic       add,
  output logic       sub,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_UP   = 2'b01,
    S_DN   = 2'b10,
    S_LOCK = 2'b11
  } state_e;

  if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 255) begin : g_bad_db
    $error("DEBOUNCE_CYCLES must be 1..255");
  end
  if (REPEAT_DELAY < 2 || REPEAT_DELAY > 65535) begin : g_bad_rd
    $error("REPEAT_DELAY must be 2..65535");
  end
  if (REPEAT_PERIOD < 2 || REPEAT_PERIOD > 65535) begin : g_bad_rp
    $error("REPEAT_PERIOD must be 2..65535");
  end

  localparam logic [7:0] DB_M1 = 8'(DEBOUNCE_CYCLES - 1);

  // Channel index 0 = up, 1 = dn.
  logic [1:0] s1_q;
  logic [1:0] s2_q;
  logic [1:0] deb_q;
  logic [1:0] prev_q;
  logic [7:0] cnt_q [2];

  state_e state_q;
  logic   add_q;
  logic   sub_q;

  logic [1:0] rise_d;
  logic       both_d;
  logic       rep_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q     <= '0;
      s2_q     <= '0;
      deb_q    <= '0;
      prev_q   <= '0;
      cnt_q[0] <= '0;
      cnt_q[1] <= '0;
    end else begin
      s1_q   <= {btn_dn, btn_up};
      s2_q   <= s1_q;
      prev_q <= deb_q;
      for (int i = 0; i < 2; i++) begin
        if (s2_q[i] == deb_q[i]) begin
          cnt_q[i] <= '0;
        end else if (cnt_q[i] == DB_M1) begin
          deb_q[i] <= s2_q[i];
          cnt_q[i] <= '0;
        end else begin
          cnt_q[i] <= cnt_q[i] + 8'd1;
        end
      end
    end
  end

  assign rise_d = deb_q & ~prev_q;
  assign both_d = &deb_q;

`ifdef STEP_PULSE_AUTO_REPEAT_EN
  localparam logic [15:0] RD_M1 = 16'(REPEAT_DELAY - 1);
  localparam logic [15:0] RP_M1 = 16'(REPEAT_PERIOD - 1);

  logic [15:0] rpt_q;
  logic        first_q;

  assign rep_d = (rpt_q == (first_q ? RD_M1 : RP_M1));

  // Timer re-arms in IDLE/LOCK so it is zero on the edge of the first pulse.
  always_ff @(posedge clk) begin
    if (rst || state_q == S_IDLE || state_q == S_LOCK) begin
      rpt_q   <= '0;
      first_q <= 1'b1;
    end else if (rep_d) begin
      rpt_q   <= '0;
      first_q <= 1'b0;
    end else if (rpt_q != 16'hFFFF) begin
      rpt_q <= rpt_q + 16'd1;
    end
  end
`else
  assign rep_d = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      add_q   <= 1'b0;
      sub_q   <= 1'b0;
    end else begin
      add_q <= 1'b0;
      sub_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (both_d) begin
            state_q <= S_LOCK;
          end else if (rise_d[0] && !deb_q[1]) begin
            state_q <= S_UP;
            add_q   <= !hold;
          end else if (rise_d[1] && !deb_q[0]) begin
            state_q <= S_DN;
            sub_q   <= !hold;
          end
        end
        S_UP: begin
          if (both_d) begin
            state_q <= S_LOCK;
          end else if (!deb_q[0]) begin
            state_q <= S_IDLE;
          end else if (rep_d) begin
            add_q <= !hold;
          end
        end
        S_DN: begin
          if (both_d) begin
            state_q <= S_LOCK;
          end else if (!deb_q[1]) begin
            state_q <= S_IDLE;
          end else if (rep_d) begin
            sub_q <= !hold;
          end
        end
        S_LOCK: begin
          if (deb_q == 2'b00) begin
            state_q <= S_IDLE;
          end
        end
      endcase
    end
  end

  assign add   = add_q;
  assign sub   = sub_q;
  assign state = state_q;

endmodule

// File: tb/tb_step_pulse_gen.sv
// Randomized and directed bench for step_pulse_gen against a
// sample-history reference model.
module tb_step_pulse_gen;

  localparam int DB = 4;
  localparam int RD = 16;
  localparam int RP = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_up;
  logic       btn_dn;
  logic       hold;
  logic       add;
  logic       sub;
  logic [1:0] state;

  always #5 clk = ~clk;

  step_pulse_gen #(
    .DEBOUNCE_CYCLES(DB),
    .REPEAT_DELAY(RD),
    .REPEAT_PERIOD(RP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .btn_up(btn_up),
    .btn_dn(btn_dn),
    .hold(hold),
    .add(add),
    .sub(sub),
    .state(state)
  );

  int n_chk = 0;
  int n_err = 0;
  int ecnt = 0;

  // Reference model: raw samples delayed two edges, a level flips once
  // the last DB delayed samples all disagree with it.
  bit m_s1[2];
  bit m_s2[2];
  bit m_deb[2];
  bit m_prev[2];
  bit hq0[$];
  bit hq1[$];
  int m_tf;
  int m_st;
  bit m_add;
  bit m_sub;

  function automatic bit flips(input bit h[$], input bit lvl);
    if (h.size() < DB) return 1'b0;
    foreach (h[i]) if (h[i] == lvl) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit repeat_due(input int k);
`ifdef STEP_PULSE_AUTO_REPEAT_EN
    return k >= RD && ((k - RD) % RP) == 0;
`else
    return (k < 0);
`endif
  endfunction

  task automatic model_step();
    bit dv[2];
    bit pv[2];
    bit nd[2];
    bit a;
    bit s;
    if (rst) begin
      m_s1 = '{0, 0};
      m_s2 = '{0, 0};
      m_deb = '{0, 0};
      m_prev = '{0, 0};
      hq0.delete();
      hq1.delete();
      m_st = 0;
      m_add = 0;
      m_sub = 0;
      return;
    end
    dv = m_deb;
    pv = m_prev;
    hq0.push_back(m_s2[0]);
    hq1.push_back(m_s2[1]);
    if (hq0.size() > DB) void'(hq0.pop_front());
    if (hq1.size() > DB) void'(hq1.pop_front());
    nd[0] = flips(hq0, dv[0]) ? !dv[0] : dv[0];
    nd[1] = flips(hq1, dv[1]) ? !dv[1] : dv[1];
    m_s2 = m_s1;
    m_s1[0] = btn_up;
    m_s1[1] = btn_dn;
    a = 0;
    s = 0;
    case (m_st)
      0: begin
        if (dv[0] && dv[1]) m_st = 3;
        else if (dv[0] && !pv[0] && !dv[1]) begin
          m_st = 1; a = 1; m_tf = ecnt;
        end else if (dv[1] && !pv[1] && !dv[0]) begin
          m_st = 2; s = 1; m_tf = ecnt;
        end
      end
      1: begin
        if (dv[0] && dv[1]) m_st = 3;
        else if (!dv[0]) m_st = 0;
        else a = repeat_due(ecnt - m_tf);
      end
      2: begin
        if (dv[0] && dv[1]) m_st = 3;
        else if (!dv[1]) m_st = 0;
        else s = repeat_due(ecnt - m_tf);
      end
      default: begin
        if (!dv[0] && !dv[1]) m_st = 0;
      end
    endcase
    m_add = a && !hold;
    m_sub = s && !hold;
    m_prev = dv;
    m_deb = nd;
  endtask

  task automatic tick();
    @(posedge clk);
    ecnt++;
    model_step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1; btn_up = 1; btn_dn = 0; hold = 0;
    repeat (3) tick();
    n_chk++;
    if ({add, sub, state} !== 4'b0000) begin
      n_err++;
      $display("FAIL reset got %b%b%b want 0000", add, sub, state);
    end
    rst = 0; btn_up = 0;
    repeat (8) begin
      tick();
      n_chk++;
      if ({add, sub, state} !== {m_add, m_sub, 2'(m_st)}) begin
        n_err++;
        $display("FAIL reset_idle e=%0d got %b%b%b want %b%b%0d",
                 ecnt, add, sub, state, m_add, m_sub, m_st);
      end
    end
  endtask

  task automatic test_up_press();
    int n0;
    int first;
    first = -1;
    btn_up = 1;
    n0 = ecnt + 1;
    repeat (70) begin
      tick();
      if (add && first < 0) first = ecnt;
      n_chk++;
      if ({add, sub, state} !== {m_add, m_sub, 2'(m_st)}) begin
        n_err++;
        $display("FAIL up_press e=%0d got %b%b%b want %b%b%0d",
                 ecnt, add, sub, state, m_add, m_sub, m_st);
      end
    end
    n_chk++;
    if (first - n0 !== 6) begin
      n_err++;
      $display("FAIL up_latency got %0d want 6", first - n0);
    end
    n_chk++;
    if (state !== 2'b01) begin
      n_err++;
      $display("FAIL up_state got %b want 01", state);
    end
    btn_up = 0;
    repeat (12) begin
      tick();
      n_chk++;
      if ({add, sub, state} !== {m_add, m_sub, 2'(m_st)}) begin
        n_err++;
        $display("FAIL up_release e=%0d got %b%b%b want %b%b%0d",
                 ecnt, add, sub, state, m_add, m_sub, m_st);
      end
    end
    n_chk++;
    if (state !== 2'b00) begin
      n_err++;
      $display("FAIL up_release_state got %b want 00", state);
    end
  endtask

  task automatic test_glitch();
    int subs;
    subs = 0;
    btn_dn = 1;
    repeat (3) tick();
    btn_dn = 0;
    repeat (15) begin
      tick();
      subs += int'(sub);
      n_chk++;
      if ({add, sub, state} !== {m_add, m_sub, 2'(m_st)}) begin
        n_err++;
        $display("FAIL glitch e=%0d got %b%b%b want %b%b%0d",
                 ecnt, add, sub, state, m_add, m_sub, m_st);
      end
    end
    n_chk++;
    if (subs !== 0 || state !== 2'b00) begin
      n_err++;
      $display("FAIL glitch_sum subs=%0d st=%b want 0 00", subs, state);
    end
  endtask

  task automatic test_lock();
    int pulses;
    btn_up = 1;
    repeat (20) tick();
    btn_dn = 1;
    repeat (30) begin
      tick();
      n_chk++;
      if ({add, sub, state} !== {m_add, m_sub, 2'(m_st)}) begin
        n_err++;
        $display("FAIL lock e=%0d got %b%b%b want %b%b%0d",
                 ecnt, add, sub, state, m_add, m_sub, m_st);
      end
    end
    n_chk++;
    if (state !== 2'b11) begin
      n_err++;
      $display("FAIL lock_state got %b want 11", state);
    end
    pulses = 0;
    btn_dn = 0;
    repeat (15) begin
      tick();
      pulses += int'(add) + int'(sub);
    end
    n_chk++;
    if (state !== 2'b11 || pulses !== 0) begin
      n_err++;
      $display("FAIL lock_dn_rel st=%b pulses=%0d want 11 0", state, pulses);
    end
    btn_up = 0;
    repeat (15) begin
      tick();
      pulses += int'(add) + int'(sub);
    end
    n_chk++;
    if (state !== 2'b00 || pulses !== 0) begin
      n_err++;
      $display("FAIL lock_exit st=%b pulses=%0d want 00 0", state, pulses);
    end
  endtask

  task automatic test_hold();
    int subs;
    subs = 0;
    hold = 1;
    btn_dn = 1;
    repeat (20) begin
      tick();
      subs += int'(sub);
    end
    n_chk++;
    if (subs !== 0 || state !== 2'b10) begin
      n_err++;
      $display("FAIL hold_press subs=%0d st=%b want 0 10", subs, state);
    end
    hold = 0;
    repeat (30) begin
      tick();
      subs += int'(sub);
      n_chk++;
      if ({add, sub, state} !== {m_add, m_sub, 2'(m_st)}) begin
        n_err++;
        $display("FAIL hold_drop e=%0d got %b%b%b want %b%b%0d",
                 ecnt, add, sub, state, m_add, m_sub, m_st);
      end
    end
`ifndef STEP_PULSE_AUTO_REPEAT_EN
    n_chk++;
    if (subs !== 0) begin
      n_err++;
      $display("FAIL hold_late subs=%0d want 0", subs);
    end
`endif
    btn_dn = 0;
    repeat (12) tick();
  endtask

  task automatic test_rst_mid();
    int n0;
    int first;
    first = -1;
    btn_up = 1;
    repeat (12) tick();
    rst = 1;
    tick();
    n_chk++;
    if ({add, sub, state} !== 4'b0000) begin
      n_err++;
      $display("FAIL rst_mid got %b%b%b want 0000", add, sub, state);
    end
    rst = 0;
    n0 = ecnt + 1;
    repeat (15) begin
      tick();
      if (add && first < 0) first = ecnt;
      n_chk++;
      if ({add, sub, state} !== {m_add, m_sub, 2'(m_st)}) begin
        n_err++;
        $display("FAIL rst_mid_run e=%0d got %b%b%b want %b%b%0d",
                 ecnt, add, sub, state, m_add, m_sub, m_st);
      end
    end
    n_chk++;
    if (first - n0 !== 6) begin
      n_err++;
      $display("FAIL rst_mid_latency got %0d want 6", first - n0);
    end
    btn_up = 0;
    repeat (12) tick();
  endtask

  task automatic test_random();
    repeat (3000) begin
      if ($urandom_range(0, 11) == 0) btn_up = ~btn_up;
      if ($urandom_range(0, 13) == 0) btn_dn = ~btn_dn;
      if ($urandom_range(0, 24) == 0) hold = ~hold;
      rst = ($urandom_range(0, 299) == 0);
      tick();
      n_chk++;
      if ({add, sub, state} !== {m_add, m_sub, 2'(m_st)}
          || (add && sub)) begin
        n_err++;
        $display("FAIL random e=%0d got %b%b%b want %b%b%0d",
                 ecnt, add, sub, state, m_add, m_sub, m_st);
      end
    end
    rst = 0;
  endtask

  initial begin
    rst = 1;
    btn_up = 0;
    btn_dn = 0;
    hold = 0;
    test_reset();
    test_up_press();
    test_glitch();
    test_lock();
    test_hold();
    test_rst_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
